// File: rtl/apb_timer_regs.sv
// APB3 register block for the 8-bit up/down timer: reload, control, status (W1C)
// and interrupt-enable registers, plus the count-tick prescaler and sticky flags.
module apb_timer_regs #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        tmr_data,
  output logic              tmr_init_cnt,
  output logic              tmr_updown,
  output logic              tmr_en,
  input  logic              tmr_over,
  input  logic              tmr_under,
  output logic              irq
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t     state_q;
  logic [2:0] wcnt_q;
  logic [7:0] tdr_q;
  logic       updown_q, en_q, load_q;
  logic [1:0] cks_q;
  logic [1:0] tsr_q, tsr_d;
  logic [1:0] tier_q;
  logic [3:0] presc_q;
  logic       over_q, under_q;

  logic       access, addr_err, commit;
  logic       wr_tdr, wr_tcr, wr_tsr, wr_tier;
  logic [2:0] cur_cnt;
  logic [7:0] rdata;
  logic [3:0] mask;
  logic [1:0] tsr_clr;
  logic       unused_wdata;

  assign unused_wdata = ^{pwdata[6], pwdata[3:2]};

  assign access   = psel & penable;
  assign addr_err = (paddr >> 2) != '0;
  // The counter holds the number of ACCESS cycles already spent; the first one is seen in IDLE.
  assign cur_cnt  = (state_q == S_WAIT) ? wcnt_q : '0;
  assign pready   = access && (state_q != S_DONE) && (cur_cnt == WS);
  assign commit   = pready & pwrite & ~addr_err;
  assign wr_tdr   = commit && (paddr[1:0] == 2'd0);
  assign wr_tcr   = commit && (paddr[1:0] == 2'd1);
  assign wr_tsr   = commit && (paddr[1:0] == 2'd2);
  assign wr_tier  = commit && (paddr[1:0] == 2'd3);

  always_comb begin
    rdata = '0;
    case (paddr[1:0])
      2'd0: rdata = tdr_q;
      2'd1: rdata = {2'b00, updown_q, en_q, 2'b00, cks_q};
      2'd2: rdata = {6'd0, tsr_q};
      2'd3: rdata = {6'd0, tier_q};
      default: rdata = '0;
    endcase
  end

  assign prdata  = (pready && !pwrite && !addr_err) ? rdata : '0;
  assign pslverr = pready & addr_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (access) begin
          wcnt_q  <= 3'd1;
          state_q <= pready ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (!access)     state_q <= S_IDLE;
          else if (pready) state_q <= S_DONE;
          else             wcnt_q  <= wcnt_q + 3'd1;
        end
        S_DONE: if (!access) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdr_q    <= '0;
      updown_q <= 1'b0;
      en_q     <= 1'b0;
      cks_q    <= '0;
      tier_q   <= '0;
      load_q   <= 1'b0;
    end else begin
      load_q <= wr_tcr & pwdata[7];
      if (wr_tdr) tdr_q <= pwdata;
      if (wr_tcr) begin
        updown_q <= pwdata[5];
        en_q     <= pwdata[4];
        cks_q    <= pwdata[1:0];
      end
      if (wr_tier) tier_q <= pwdata[1:0];
    end
  end

  // Any TCR write restarts the prescaler, so it is already 0 during the load pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                presc_q <= '0;
    else if (wr_tcr || !en_q)  presc_q <= '0;
    else                       presc_q <= presc_q + 4'd1;
  end

  always_comb begin
    mask = 4'h1;
    case (cks_q)
      2'd0: mask = 4'h1;
      2'd1: mask = 4'h3;
      2'd2: mask = 4'h7;
      2'd3: mask = 4'hF;
      default: mask = 4'h1;
    endcase
  end

  assign tmr_en = en_q && ((presc_q & mask) == mask);

  // A new edge wins over a simultaneous write-1-to-clear.
  assign tsr_clr = wr_tsr ? pwdata[1:0] : 2'b00;
  assign tsr_d   = (tsr_q & ~tsr_clr) | {tmr_under & ~under_q, tmr_over & ~over_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tsr_q   <= '0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      tsr_q   <= tsr_d;
      over_q  <= tmr_over;
      under_q <= tmr_under;
    end
  end

  assign tmr_data     = tdr_q;
  assign tmr_updown   = updown_q;
  assign tmr_init_cnt = load_q;
  assign irq          = |(tsr_q & tier_q);

endmodule

// File: tb/tb_apb_timer_regs.sv
// Scoreboard bench for apb_timer_regs: APB responses are queued by the stimulus
// and checked by a monitor on every pready; timer sideband is checked inline.
module tb_apb_timer_regs;

  localparam int unsigned WS = 1;

  logic       clk, rst_n, psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata, tmr_data;
  logic       pready, pslverr, tmr_init_cnt, tmr_updown, tmr_en;
  logic       tmr_over, tmr_under, irq;

  apb_timer_regs #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .tmr_data(tmr_data), .tmr_init_cnt(tmr_init_cnt),
    .tmr_updown(tmr_updown), .tmr_en(tmr_en), .tmr_over(tmr_over),
    .tmr_under(tmr_under), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rd;
    logic       err;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    int   acc;
    exp_t e;
    acc = 0;
    forever begin
      @(negedge clk);
      if (rst_n && psel && penable) begin
        acc++;
        if (pready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pready: got pready=1 expected no transfer pending");
          end else begin
            e = q.pop_front();
            chk({e.nm, "_prdata"}, prdata, e.rd);
            chk({e.nm, "_pslverr"}, 8'(pslverr), 8'(e.err));
            chk({e.nm, "_latency"}, 8'(acc), 8'(WS + 1));
          end
          acc = 0;
        end
      end else begin
        acc = 0;
      end
    end
  end

  task automatic apb(input string nm, input logic wr, input logic [7:0] addr,
                     input logic [7:0] wd, input logic [7:0] erd, input logic eerr,
                     input logic under_at_ready);
    exp_t e;
    int   n;
    e.rd  = wr ? 8'h00 : erd;
    e.err = eerr;
    e.nm  = nm;
    q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (pready) break;
      n++;
      if (n > 20) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no pready in %0d cycles expected pready", nm, n);
        break;
      end
    end
    if (under_at_ready) tmr_under = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, first;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; tmr_over = 1'b0; tmr_under = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata", prdata, 8'h00);
    chk("rst_tmr_data", tmr_data, 8'h00);
    chk("rst_flags", {pready, pslverr, tmr_init_cnt, tmr_updown, tmr_en, irq, 2'b00}, 8'h00);
    rst_n = 1'b1;
    step();

    apb("rd_tcr_rst", 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
    apb("wr_tdr", 1'b1, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0);
    chk("tmr_data_a5", tmr_data, 8'hA5);
    apb("rd_tdr", 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0);

    // LOAD | UPDOWN | EN | CKS=1: load pulse in cycle 1, ticks every 4th cycle
    apb("wr_tcr_b1", 1'b1, 8'h01, 8'hB1, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("init_cnt_k%0d", k), 8'(tmr_init_cnt), 8'(k == 1));
      chk($sformatf("tick_cks1_k%0d", k), 8'(tmr_en), 8'(k % 4 == 0));
      step();
    end
    chk("updown", 8'(tmr_updown), 8'h01);
    apb("rd_tcr_31", 1'b0, 8'h01, 8'h00, 8'h31, 1'b0, 1'b0);

    apb("wr_tcr_33", 1'b1, 8'h01, 8'h33, 8'h00, 1'b0, 1'b0);
    apb("wr_tcr_23", 1'b1, 8'h01, 8'h23, 8'h00, 1'b0, 1'b0);
    ticks = 0;
    for (int k = 1; k <= 40; k++) begin
      if (tmr_en) ticks++;
      step();
    end
    chk("no_tick_disabled", 8'(ticks), 8'd0);

    apb("wr_tcr_33b", 1'b1, 8'h01, 8'h33, 8'h00, 1'b0, 1'b0);
    chk("no_load_pulse", 8'(tmr_init_cnt), 8'h00);
    ticks = 0; first = 0;
    for (int k = 1; k <= 32; k++) begin
      if (tmr_en) begin
        ticks++;
        if (first == 0) first = k;
      end
      step();
    end
    chk("first_tick_cks3", 8'(first), 8'd16);
    chk("tick_count_cks3", 8'(ticks), 8'd2);
    apb("wr_tcr_00", 1'b1, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);

    tmr_over = 1'b1;
    repeat (5) step();
    tmr_over = 1'b0;
    apb("rd_tsr_ovf", 1'b0, 8'h02, 8'h00, 8'h01, 1'b0, 1'b0);
    chk("irq_tier0", 8'(irq), 8'h00);
    apb("wr_tier_01", 1'b1, 8'h03, 8'h01, 8'h00, 1'b0, 1'b0);
    chk("irq_ovf_en", 8'(irq), 8'h01);
    apb("wr_tsr_01", 1'b1, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0);
    chk("irq_cleared", 8'(irq), 8'h00);
    apb("rd_tsr_clr", 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);

    // held level: cleared while still high must not set again
    tmr_over = 1'b1;
    step();
    apb("wr_tsr_held", 1'b1, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0);
    apb("rd_tsr_held", 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
    tmr_over = 1'b0;

    apb("wr_tsr_udf_race", 1'b1, 8'h02, 8'h02, 8'h00, 1'b0, 1'b1);
    tmr_under = 1'b0;
    apb("rd_tsr_udf", 1'b0, 8'h02, 8'h00, 8'h02, 1'b0, 1'b0);
    chk("irq_udf_masked", 8'(irq), 8'h00);
    apb("wr_tier_03", 1'b1, 8'h03, 8'h03, 8'h00, 1'b0, 1'b0);
    chk("irq_udf_en", 8'(irq), 8'h01);
    apb("wr_tsr_02", 1'b1, 8'h02, 8'h02, 8'h00, 1'b0, 1'b0);
    apb("rd_tsr_udf_clr", 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("irq_udf_clr", 8'(irq), 8'h00);

    apb("wr_bad_addr", 1'b1, 8'h04, 8'hFF, 8'h00, 1'b1, 1'b0);
    apb("rd_bad_addr", 1'b0, 8'h84, 8'h00, 8'h00, 1'b1, 1'b0);
    apb("rd_tdr_keep", 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0);
    apb("rd_tcr_keep", 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
    apb("rd_tsr_keep", 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
    apb("rd_tier_keep", 1'b0, 8'h03, 8'h00, 8'h03, 1'b0, 1'b0);

    // reset asserted in the middle of a waited write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 8'h02;
    step();
    penable = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pready", 8'(pready), 8'h00);
    chk("rst_mid_tmr_data", tmr_data, 8'h00);
    chk("rst_mid_flags", {pslverr, tmr_init_cnt, tmr_updown, tmr_en, irq, 3'b000}, 8'h00);
    step();
    chk("rst_mid_pready_hold", 8'(pready), 8'h00);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rst_n = 1'b1;
    step();
    apb("rd_tier_after_rst", 1'b0, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0);
    apb("rd_tdr_after_rst", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    repeat (2) step();
    chk("queue_empty", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
